tanh_job_scheduler: RTL and testbench

Queues tanh batch jobs (source base, destination base, element count) and sequences the tanh datapath over each one. For every job it issues one read per element, then one write per element after a fixed pipeline latency. It replaces the single-shot RUN/BUSY handshake with a buffered job queue, so the host can post several jobs back-to-back. It sits between the host/command interface and the tanh datapath plus scratchpad SRAM.

---
 rtl/tanh_pkg.sv | 23 ++
 rtl/job_fifo.sv | 70 +++++++
 rtl/tanh_job_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_tanh_job_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared definitions for the tanh job scheduler.
//   TANH_ADDR_W : default scratchpad address / job length width
//   state_t     : scheduler FSM encoding (IDLE, START, ISSUE, DRAIN, DONE)
//   job_t       : job record {src, dst, len} at the default address width
package tanh_pkg;

  localparam int TANH_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [TANH_ADDR_W-1:0] src;
    logic [TANH_ADDR_W-1:0] dst;
    logic [TANH_ADDR_W-1:0] len;
  } job_t;

endpackage

// File: rtl/job_fifo.sv
// Synchronous first-word-fall-through FIFO of job records.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   push, push_data   : write request and record (ignored when full or in reset)
//   pop, pop_data     : read request; pop_data always shows the head entry
//   count             : number of stored entries (0..DEPTH)
//   full, empty       : occupancy flags
// A push and a pop in the same cycle are both honoured; count is unchanged.
module job_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // The queue is only a handful of entries deep, so the head is read
  // combinationally; this lets the FSM pop and load a job in one cycle.
  assign pop_data = mem[rd_ptr_reg];

  // Storage has no reset: entries are only meaningful below count_reg.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tanh_job_scheduler.sv
// Buffered job scheduler for the tanh datapath.
// Jobs {src, dst, len} are queued from the host; each is sequenced as one
// read per element followed, PIPE_LAT cycles later, by one write per element.
// Ports:
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   job_valid/job_ready           : host job handshake (push on valid && ready)
//   job_src, job_dst, job_len     : job record; len==0 is a legal no-op
//   read_enable, read_address     : read strobe and source address to SRAM/datapath
//   write_enable, write_address   : write strobe and destination address of result
//   restart                       : one-cycle pulse at job start (clears datapath)
//   done                          : one-cycle pulse per completed job
//   BUSY                          : queue non-empty or a job in progress
module tanh_job_scheduler
  import tanh_pkg::*;
#(
  parameter int ADDR_W     = TANH_ADDR_W,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_src,
  input  logic [ADDR_W-1:0] job_dst,
  input  logic [ADDR_W-1:0] job_len,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_address,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic              restart,
  output logic              done,
  output logic              BUSY
);

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
  } job_rec_t;

  localparam int JOB_W = $bits(job_rec_t);

  // Stages below the output stage; any bit set here means a write is still
  // due after the current cycle.
  localparam logic [PIPE_LAT-1:0] PEND_MASK = {PIPE_LAT{1'b1}} >> 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, dst_reg, len_reg;
  logic [ADDR_W-1:0] rd_cnt_reg, wr_cnt_reg;
  logic [ADDR_W-1:0] rd_hold_reg, wr_hold_reg;
  logic [PIPE_LAT-1:0] pipe_reg;

  job_rec_t          push_rec, head_rec;
  logic [JOB_W-1:0]  head_bits;
  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic              pipe_pending;
  logic              rd_last;

  // ------------------------------------------------------------------
  // Job queue
  // ------------------------------------------------------------------
  assign push_rec  = '{src: job_src, dst: job_dst, len: job_len};
  assign head_rec  = job_rec_t'(head_bits);
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign job_ready = !fifo_full;
  assign fifo_push = job_valid && job_ready;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

  job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_job_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign BUSY = (state_reg != ST_IDLE) || (fifo_count != '0);

  // ------------------------------------------------------------------
  // Read-valid latency pipe: write_enable is read_enable delayed PIPE_LAT
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_reg[0] <= 1'b0;
    end else begin
      pipe_reg[0] <= read_enable;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < PIPE_LAT; gi++) begin : g_pipe
      always_ff @(posedge clock) begin
        if (reset) begin
          pipe_reg[gi] <= 1'b0;
        end else begin
          pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pipe_pending = |(pipe_reg & PEND_MASK);
  assign write_enable = pipe_reg[PIPE_LAT-1];

  // Addresses follow the live counters while strobed and otherwise show the
  // last address actually issued.
  assign read_address  = read_enable  ? (src_reg + rd_cnt_reg) : rd_hold_reg;
  assign write_address = write_enable ? (dst_reg + wr_cnt_reg) : wr_hold_reg;

  // ------------------------------------------------------------------
  // FSM: next state and strobes
  // ------------------------------------------------------------------
  assign rd_last = (rd_cnt_reg == (len_reg - ADDR_W'(1)));

  always_comb begin
    state_next  = state_reg;
    read_enable = 1'b0;
    restart     = 1'b0;
    done        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        restart    = 1'b1;
        state_next = (len_reg == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        read_enable = 1'b1;
        if (rd_last) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave in the cycle of the final write so done follows it directly.
        if (!pipe_pending) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State, job registers, counters and address hold registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
      rd_hold_reg <= '0;
      wr_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) begin
        src_reg <= head_rec.src;
        dst_reg <= head_rec.dst;
        len_reg <= head_rec.len;
      end
      // The previous job has fully drained before START, so no write can
      // collide with the counter clear.
      if (state_reg == ST_START) begin
        rd_cnt_reg <= '0;
        wr_cnt_reg <= '0;
      end else begin
        if (read_enable) begin
          rd_cnt_reg <= rd_cnt_reg + ADDR_W'(1);
        end
        if (write_enable) begin
          wr_cnt_reg <= wr_cnt_reg + ADDR_W'(1);
        end
      end
      if (read_enable) begin
        rd_hold_reg <= read_address;
      end
      if (write_enable) begin
        wr_hold_reg <= write_address;
      end
    end
  end

endmodule

// File: tb/tb_tanh_job_scheduler.sv
// Directed bench for tanh_job_scheduler. Two instances share clock and
// reset: index 0 is built with PIPE_LAT=3, index 1 with PIPE_LAT=1.
// Expected strobes/addresses come from the documented cycle timeline of a
// single job whose handshake completes at the end of cycle 0.
module tb_tanh_job_scheduler;
  import tanh_pkg::*;

  localparam int AW = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          job_valid     [2];
  logic [AW-1:0] job_src       [2];
  logic [AW-1:0] job_dst       [2];
  logic [AW-1:0] job_len       [2];
  logic          job_ready     [2];
  logic          read_enable   [2];
  logic [AW-1:0] read_address  [2];
  logic          write_enable  [2];
  logic [AW-1:0] write_address [2];
  logic          restart       [2];
  logic          done          [2];
  logic          busy          [2];

  int tests_run    = 0;
  int tests_failed = 0;

  tanh_job_scheduler #(.ADDR_W(AW), .PIPE_LAT(3), .FIFO_DEPTH(4)) dut_lat3 (
    .clock(clock), .reset(reset),
    .job_valid(job_valid[0]), .job_ready(job_ready[0]),
    .job_src(job_src[0]), .job_dst(job_dst[0]), .job_len(job_len[0]),
    .read_enable(read_enable[0]), .read_address(read_address[0]),
    .write_enable(write_enable[0]), .write_address(write_address[0]),
    .restart(restart[0]), .done(done[0]), .BUSY(busy[0])
  );

  tanh_job_scheduler #(.ADDR_W(AW), .PIPE_LAT(1), .FIFO_DEPTH(4)) dut_lat1 (
    .clock(clock), .reset(reset),
    .job_valid(job_valid[1]), .job_ready(job_ready[1]),
    .job_src(job_src[1]), .job_dst(job_dst[1]), .job_len(job_len[1]),
    .read_enable(read_enable[1]), .read_address(read_address[1]),
    .write_enable(write_enable[1]), .write_address(write_address[1]),
    .restart(restart[1]), .done(done[1]), .BUSY(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the edge itself.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] flags(input int d);
    return {read_enable[d], write_enable[d], restart[d], done[d], busy[d]};
  endfunction

  task automatic load_job(input int d, input logic [AW-1:0] s, input logic [AW-1:0] t,
                          input logic [AW-1:0] n);
    job_src[d] = s;
    job_dst[d] = t;
    job_len[d] = n;
  endtask

  // Post one job into an idle scheduler and check every cycle up to and
  // including the cycle where BUSY is expected low again.
  task automatic run_single(input int d, input logic [AW-1:0] s, input logic [AW-1:0] t,
                            input int n, input int lat, input string tag);
    int            dn;
    logic [4:0]    exp;
    logic [AW-1:0] ea;
    check({tag, ".ready"}, 32'(job_ready[d]), 32'd1);
    load_job(d, s, t, AW'(n));
    job_valid[d] = 1'b1;
    step();
    job_valid[d] = 1'b0;
    dn = (n == 0) ? 3 : 3 + n + lat;
    for (int c = 1; c <= dn + 1; c++) begin
      exp = {(c >= 3) && (c <= 2 + n),
             (c >= 3 + lat) && (c <= 2 + n + lat),
             (c == 2), (c == dn), (c <= dn)};
      check($sformatf("%s.c%0d.flags", tag, c), 32'(flags(d)), 32'(exp));
      if (exp[4]) begin
        ea = s + AW'(c - 3);
        check($sformatf("%s.c%0d.rd_addr", tag, c), 32'(read_address[d]), 32'(ea));
      end
      if (exp[3]) begin
        ea = t + AW'(c - 3 - lat);
        check($sformatf("%s.c%0d.wr_addr", tag, c), 32'(write_address[d]), 32'(ea));
      end
      step();
    end
    $display("[TB] job %s: src=0x%03h dst=0x%03h len=%0d lat=%0d", tag, s, t, n, lat);
  endtask

  job_t q_jobs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc;
    int            started;
    int            dones;
    int            last_done;
    int            rk;
    int            wk;
    bit            acc_now;
    logic [AW-1:0] ea;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      job_valid[d] = 1'b0;
      load_job(d, '0, '0, '0);
    end
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d.flags", d), 32'(flags(d)), 32'd0);
      check($sformatf("rst%0d.ready", d), 32'(job_ready[d]), 32'd1);
      check($sformatf("rst%0d.rd_addr", d), 32'(read_address[d]), 32'd0);
      check($sformatf("rst%0d.wr_addr", d), 32'(write_address[d]), 32'd0);
    end

    run_single(0, 12'h010, 12'h800, 4, 3, "single");
    run_single(0, 12'h123, 12'h456, 0, 3, "len0");
    run_single(0, 12'hFFE, 12'hFFF, 3, 3, "wrap");
    run_single(1, 12'h020, 12'h300, 4, 1, "lat1");
    run_single(1, 12'hFFF, 12'h000, 2, 1, "lat1_wrap");

    // Queue full: six jobs offered back-to-back with job_valid held high.
    q_jobs[0] = '{src: 12'h100, dst: 12'hA00, len: 12'd3};
    q_jobs[1] = '{src: 12'h200, dst: 12'hA10, len: 12'd1};
    q_jobs[2] = '{src: 12'h300, dst: 12'hA20, len: 12'd2};
    q_jobs[3] = '{src: 12'h400, dst: 12'hA30, len: 12'd4};
    q_jobs[4] = '{src: 12'h500, dst: 12'hA40, len: 12'd2};
    q_jobs[5] = '{src: 12'h600, dst: 12'hA50, len: 12'd1};
    acc = 0; started = -1; dones = 0; last_done = -100; rk = 0; wk = 0;
    load_job(0, q_jobs[0].src, q_jobs[0].dst, q_jobs[0].len);
    job_valid[0] = 1'b1;
    for (int c = 0; c < 400 && dones < 6; c++) begin
      if (restart[0]) begin
        started++;
        rk = 0;
        wk = 0;
        if (started > 0) begin
          check($sformatf("q.gap%0d", started), 32'(c - last_done), 32'd2);
        end
      end
      if (started >= 0 && started < 6) begin
        if (read_enable[0]) begin
          ea = q_jobs[started].src + AW'(rk);
          check($sformatf("q.j%0d.rd%0d", started, rk), 32'(read_address[0]), 32'(ea));
          rk++;
        end
        if (write_enable[0]) begin
          ea = q_jobs[started].dst + AW'(wk);
          check($sformatf("q.j%0d.wr%0d", started, wk), 32'(write_address[0]), 32'(ea));
          wk++;
        end
        if (done[0]) begin
          check($sformatf("q.j%0d.reads", started), 32'(rk), 32'(q_jobs[started].len));
          check($sformatf("q.j%0d.writes", started), 32'(wk), 32'(q_jobs[started].len));
          $display("[TB] queued job %0d done at cycle %0d", started, c);
          dones++;
          last_done = c;
        end
      end
      acc_now = job_valid[0] && job_ready[0];
      step();
      if (acc_now) begin
        acc++;
        if (acc == 5) begin
          check("q.ready_after_5th", 32'(job_ready[0]), 32'd0);
        end
        if (acc < 6) begin
          load_job(0, q_jobs[acc].src, q_jobs[acc].dst, q_jobs[acc].len);
        end else begin
          job_valid[0] = 1'b0;
        end
      end
    end
    job_valid[0] = 1'b0;
    check("q.accepts", 32'(acc), 32'd6);
    check("q.starts", 32'(started + 1), 32'd6);
    check("q.dones", 32'(dones), 32'd6);
    step();
    check("q.busy_end", 32'(busy[0]), 32'd0);

    // Reset mid-ISSUE: len=8, reset asserted in the 3rd read cycle, with a
    // job offered during reset that must be ignored.
    load_job(0, 12'h040, 12'h900, 12'd8);
    job_valid[0] = 1'b1;
    step();                       // cycle 1
    job_valid[0] = 1'b0;
    repeat (4) step();            // cycle 5: third read
    check("mid.rd_active", 32'(read_enable[0]), 32'd1);
    check("mid.rd_addr", 32'(read_address[0]), 32'h042);
    reset = 1'b1;
    load_job(0, 12'h070, 12'h970, 12'd2);
    job_valid[0] = 1'b1;
    step();                       // cycle 6: reset has taken effect
    reset = 1'b0;
    job_valid[0] = 1'b0;
    check("mid.flags", 32'(flags(0)), 32'd0);
    check("mid.ready", 32'(job_ready[0]), 32'd1);
    check("mid.rd_addr0", 32'(read_address[0]), 32'd0);
    check("mid.wr_addr0", 32'(write_address[0]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("mid.quiet%0d", k), 32'(flags(0)), 32'd0);
    end
    run_single(0, 12'h0A0, 12'h0B0, 2, 3, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
